// File: rtl/arbitro_barramento_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : barramento_pkg
//  Purpose  : Shared constants and types for the 6-port bus arbiter: default
//             port count, port index names, ctrl bit positions, FSM state type.
//  Revision : 1.0 - initial release
// ============================================================================
package barramento_pkg;

    localparam int N_PORTS_DEF = 6;

    // Port indices on the shared bus
    localparam int PILHA   = 0;
    localparam int MEMORIA = 1;
    localparam int TEMP1   = 2;
    localparam int TEMP2   = 3;
    localparam int ULA     = 4;
    localparam int UC      = 5;

    // Bit positions inside each port's 2-bit ctrl field
    localparam int CTRL_LER      = 0;
    localparam int CTRL_ESCREVER = 1;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ESCREVE = 2'd1,
        LE      = 2'd2,
        FIM     = 2'd3
    } estado_t;

endpackage

`default_nettype wire

// File: rtl/arbitro_barramento_rr_arbitro.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbitro
//  Purpose  : Combinational round-robin picker. Searches upward from the
//             pointer (wrapping) and returns the first requester as one-hot
//             and as an index.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbitro
    import barramento_pkg::*;
#(
    parameter int N  = N_PORTS_DEF,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] winner_idx,
    output logic          valid
);

    // First set request at or after ptr, wrapping past N-1 back to 0
    always_comb begin
        int cand;
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        cand       = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                winner[cand] = 1'b1;
                winner_idx   = IW'(cand);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/arbitro_barramento.sv
`default_nettype none
// ============================================================================
//  Module   : arbitro_barramento
//  Purpose  : Sequences transfers on the shared 16-bit bus. Picks one source
//             round-robin, holds its escrever bit for BUS_LAT cycles so the
//             registered bus path settles, then raises ler on the latched
//             destinations for one cycle and pulses done to the source.
//  Revision : 1.0 - initial release
// ============================================================================
module arbitro_barramento
    import barramento_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int BUS_LAT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_PORTS-1:0]           req_i,
    input  logic [N_PORTS*N_PORTS-1:0]   dst_i,
    output logic [2*N_PORTS-1:0]         ctrl_o,
    output logic [N_PORTS-1:0]           grant_o,
    output logic                         busy_o,
    output logic [N_PORTS-1:0]           done_o
);

    localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CW = $clog2(BUS_LAT + 1);

    estado_t              state;
    logic [N_PORTS-1:0]   grant;
    logic [IW-1:0]        src_idx;
    logic [N_PORTS-1:0]   dst_mask;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        rr_ptr;

    logic [N_PORTS-1:0]   win_onehot;
    logic [IW-1:0]        win_idx;
    logic                 win_valid;
    logic [N_PORTS-1:0]   win_dst;

    rr_arbitro #(
        .N  (N_PORTS),
        .IW (IW)
    ) u_rr (
        .req        (req_i),
        .ptr        (rr_ptr),
        .winner     (win_onehot),
        .winner_idx (win_idx),
        .valid      (win_valid)
    );

    // Destination mask belonging to the current winner
    always_comb begin
        win_dst = '0;
        for (int s = 0; s < N_PORTS; s++) begin
            if (win_onehot[s]) begin
                win_dst = dst_i[s*N_PORTS +: N_PORTS];
            end
        end
    end

    // Transfer sequencer: grant/mask latch in IDLE, BUS_LAT-cycle write window, pointer advance in FIM
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            src_idx  <= '0;
            dst_mask <= '0;
            cnt      <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        grant    <= win_onehot;
                        src_idx  <= win_idx;
                        // A source never reads its own write
                        dst_mask <= win_dst & ~win_onehot;
                        cnt      <= CW'(BUS_LAT);
                        state    <= ESCREVE;
                    end
                end
                ESCREVE: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= LE;
                    end
                end
                LE: begin
                    state <= FIM;
                end
                FIM: begin
                    grant  <= '0;
                    rr_ptr <= (src_idx == IW'(N_PORTS - 1)) ? '0 : src_idx + IW'(1);
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Per-port ctrl decode from state, owner and latched destination mask
    always_comb begin
        ctrl_o = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (state == ESCREVE || state == LE) begin
                ctrl_o[2*p + CTRL_ESCREVER] = grant[p];
            end
            if (state == LE) begin
                ctrl_o[2*p + CTRL_LER] = dst_mask[p];
            end
        end
    end

    assign grant_o = grant;
    assign busy_o  = (state != IDLE);
    assign done_o  = (state == FIM) ? grant : '0;

endmodule

`default_nettype wire

// File: tb/tb_arbitro_barramento.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arbitro_barramento
//  Purpose  : Directed self-checking bench for arbitro_barramento
//             (N_PORTS=6, BUS_LAT=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_barramento;

    logic        clk;
    logic        rst;
    logic [5:0]  req;
    logic [35:0] dst;
    logic [11:0] ctrl;
    logic [5:0]  grant;
    logic        busy;
    logic [5:0]  done;

    int checks = 0;
    int errors = 0;

    arbitro_barramento #(
        .N_PORTS (6),
        .BUS_LAT (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req),
        .dst_i   (dst),
        .ctrl_o  (ctrl),
        .grant_o (grant),
        .busy_o  (busy),
        .done_o  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer; the request must already be driven before the call
    task automatic xfer(input string tag, input int src, input logic [11:0] le_ctrl,
                        input bit mid_change, input logic [5:0] new_dst);
        logic [11:0] w;
        logic [5:0]  g;
        w = '0;
        w[2*src+1] = 1'b1;
        g = '0;
        g[src] = 1'b1;
        tick();
        chk($sformatf("%s_c1_grant", tag), 32'(grant), 32'(g));
        chk($sformatf("%s_c1_busy", tag), 32'(busy), 32'd1);
        chk($sformatf("%s_c1_ctrl", tag), 32'(ctrl), 32'(w));
        if (mid_change) begin
            req[src] = 1'b0;
            dst[src*6 +: 6] = new_dst;
        end
        tick();
        chk($sformatf("%s_c2_ctrl", tag), 32'(ctrl), 32'(w));
        tick();
        chk($sformatf("%s_c3_ctrl", tag), 32'(ctrl), 32'(le_ctrl));
        tick();
        chk($sformatf("%s_c4_done", tag), 32'(done), 32'(g));
        chk($sformatf("%s_c4_ctrl", tag), 32'(ctrl), 32'd0);
        req[src] = 1'b0;
        tick();
        chk($sformatf("%s_c5_busy", tag), 32'(busy), 32'd0);
        chk($sformatf("%s_c5_grant", tag), 32'(grant), 32'd0);
        chk($sformatf("%s_c5_done", tag), 32'(done), 32'd0);
    endtask

    // Bus-wide invariants: at most one writer, no port both reading and writing
    always @(negedge clk) begin
        int nw;
        bit both;
        if (rst === 1'b0) begin
            nw = 0;
            both = 1'b0;
            for (int p = 0; p < 6; p++) begin
                if (ctrl[2*p+1]) nw++;
                if (ctrl[2*p+1] && ctrl[2*p]) both = 1'b1;
            end
            chk("inv_single_writer", 32'(nw <= 1), 32'd1);
            chk("inv_no_rd_wr", 32'(both), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ord [7];
        logic [5:0] prev;
        int n;
        int last;

        ord[0] = 6'b000001; ord[1] = 6'b000010; ord[2] = 6'b000100;
        ord[3] = 6'b001000; ord[4] = 6'b010000; ord[5] = 6'b100000;
        ord[6] = 6'b000001;

        // ---- reset state
        rst = 1'b1;
        req = '0;
        dst = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_ctrl", 32'(ctrl), 32'd0);
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);

        // ---- contention: all ports requesting, served 0..5 then 0 again, 5 cycles apart
        req = 6'b111111;
        n = 0;
        last = 0;
        prev = '0;
        for (int cyc = 1; cyc <= 60 && n < 7; cyc++) begin
            tick();
            if (grant != 6'b0 && prev == 6'b0) begin
                chk($sformatf("cont_grant%0d", n), 32'(grant), 32'(ord[n]));
                if (n > 0) chk($sformatf("cont_gap%0d", n), 32'(cyc - last), 32'd5);
                last = cyc;
                n++;
                if (n == 7) req = '0;
            end
            prev = grant;
        end
        chk("cont_count", 32'(n), 32'd7);
        for (int k = 0; k < 10 && busy; k++) tick();
        chk("cont_idle", 32'(busy), 32'd0);

        // ---- single transfer ula -> temp1: ler temp1 only on the LE cycle
        dst[4*6 +: 6] = 6'b000100;
        req = 6'b010000;
        xfer("ula", 4, 12'h210, 1'b0, 6'b0);

        // ---- pointer wrap: serve port 5, then 0 and 5 requesting -> 0 first, then 5
        dst[5*6 +: 6] = 6'b000000;
        dst[0*6 +: 6] = 6'b000000;
        req = 6'b100000;
        xfer("uc_alone", 5, 12'h800, 1'b0, 6'b0);
        req = 6'b100001;
        xfer("wrap_pilha", 0, 12'h002, 1'b0, 6'b0);
        xfer("wrap_uc", 5, 12'h800, 1'b0, 6'b0);

        // ---- self-only mask: no ler bit, done still pulses
        dst[1*6 +: 6] = 6'b000010;
        req = 6'b000010;
        xfer("self_mask", 1, 12'h008, 1'b0, 6'b0);

        // ---- drop req and flip dst mid-transfer: original dst read, no regrant
        dst[3*6 +: 6] = 6'b000001;
        req = 6'b001000;
        xfer("midchg", 3, 12'h081, 1'b1, 6'b100000);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("midchg_nogrant%0d", k), 32'(grant), 32'd0);
        end

        // ---- reset held 2 cycles in ESCREVE, then pointer back at port 0
        req = 6'b000100;
        tick();
        chk("rst_pre_grant", 32'(grant), 32'h04);
        rst = 1'b1;
        tick();
        tick();
        chk("rst_mid_ctrl", 32'(ctrl), 32'd0);
        chk("rst_mid_grant", 32'(grant), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        rst = 1'b0;
        req = 6'b111111;
        tick();
        chk("rst_next_grant", 32'(grant), 32'h01);
        req = '0;
        for (int k = 0; k < 10 && busy; k++) tick();
        chk("final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
